// File: rtl/nios_system_sysid_checker.sv
// Avalon-MM read master that fetches sysid word 0 (ID) and word 1 (timestamp)
// and reports match/mismatch/timeout to the boot sequencer and a status PIO.
module nios_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1479449597,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ID_REQ  = 3'd1,
    S_ID_WAIT = 3'd2,
    S_TS_REQ  = 3'd3,
    S_TS_WAIT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // One bit wider than the limit so an acceptance on the limit cycle cannot wrap.
  localparam logic [16:0] LIMIT = 17'(TIMEOUT_CYCLES);

  state_t      r_state, w_state_next;
  logic [16:0] r_cnt, w_cnt_next;
  logic        r_id_ok, w_id_ok_next;
  logic        r_ts_ok, w_ts_ok_next;
  logic        r_timeout, w_timeout_next;
  logic [31:0] r_id_value, w_id_value_next;
  logic [31:0] r_ts_value, w_ts_value_next;
  logic        w_at_limit;
  logic [16:0] w_cnt_inc;

  assign w_at_limit = (r_cnt >= LIMIT);
  assign w_cnt_inc  = r_cnt + 17'd1;

  // Next-state, counter and result update logic.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_id_ok_next    = r_id_ok;
    w_ts_ok_next    = r_ts_ok;
    w_timeout_next  = r_timeout;
    w_id_value_next = r_id_value;
    w_ts_value_next = r_ts_value;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next    = S_ID_REQ;
          w_cnt_next      = 17'd0;
          w_id_ok_next    = 1'b0;
          w_ts_ok_next    = 1'b0;
          w_timeout_next  = 1'b0;
          w_id_value_next = 32'd0;
          w_ts_value_next = 32'd0;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_ID_REQ, S_TS_REQ: begin
        // Acceptance on the limit cycle completes the command phase.
        if (!avm_waitrequest) begin
          w_state_next = (r_state == S_ID_REQ) ? S_ID_WAIT : S_TS_WAIT;
          w_cnt_next   = w_cnt_inc;
        end else if (w_at_limit) begin
          w_state_next   = S_DONE;
          w_timeout_next = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_ID_WAIT: begin
        if (avm_readdatavalid) begin
          w_id_value_next = avm_readdata;
          w_id_ok_next    = (avm_readdata == EXPECTED_ID);
          w_cnt_next      = 17'd0;
          w_state_next    = S_TS_REQ;
        end else if (w_at_limit) begin
          w_state_next   = S_DONE;
          w_timeout_next = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_TS_WAIT: begin
        if (avm_readdatavalid) begin
          w_ts_value_next = avm_readdata;
          w_ts_ok_next    = (avm_readdata == EXPECTED_TIMESTAMP);
          w_cnt_next      = 17'd0;
          w_state_next    = S_DONE;
        end else if (w_at_limit) begin
          w_state_next   = S_DONE;
          w_timeout_next = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 17'd0;
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 17'd0;
      end
    endcase
  end

  // State, counter and result registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 17'd0;
      r_id_ok    <= 1'b0;
      r_ts_ok    <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_value <= 32'd0;
      r_ts_value <= 32'd0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_id_ok    <= w_id_ok_next;
      r_ts_ok    <= w_ts_ok_next;
      r_timeout  <= w_timeout_next;
      r_id_value <= w_id_value_next;
      r_ts_value <= w_ts_value_next;
    end
  end

  assign avm_read    = (r_state == S_ID_REQ) || (r_state == S_TS_REQ);
  assign avm_address = (r_state == S_TS_REQ);
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign id_ok       = r_id_ok;
  assign ts_ok       = r_ts_ok;
  assign timeout     = r_timeout;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;

endmodule
